jtag_dr_scan_ctrl: RTL and testbench



---
 rtl/jtag_dr_scan_ctrl_if.sv | 32 +++
 rtl/jtag_dr_scan_ctrl.sv | 114 +++++++++++
 tb/tb_jtag_dr_scan_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dr_scan_ctrl_if.sv
// Bundles the TAP strobes, serial data and solver handshake seen by jtag_dr_scan_ctrl.
// slave = the scan controller, master = the BSCAN/solver side driving it.
interface jtag_dr_scan_ctrl_if #(
  parameter int BYTE_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32
);
  logic                    tdi;
  logic                    tdo;
  logic                    ir_is_user;
  logic                    capture_dr;
  logic                    shift_dr;
  logic                    update_dr;
  logic [BYTE_WIDTH-1:0]   byte_data;
  logic                    byte_valid;
  logic                    byte_ready;
  logic [RESULT_WIDTH-1:0] result;
  logic                    result_valid;
  logic                    overflow;
  logic                    len_error;

  modport slave (
    input  tdi, ir_is_user, capture_dr, shift_dr, update_dr,
    input  byte_ready, result, result_valid,
    output tdo, byte_data, byte_valid, overflow, len_error
  );

  modport master (
    output tdi, ir_is_user, capture_dr, shift_dr, update_dr,
    output byte_ready, result, result_valid,
    input  tdo, byte_data, byte_valid, overflow, len_error
  );
endinterface

// File: rtl/jtag_dr_scan_ctrl.sv
// USER DR scan sequencer: classifies each scan by length into byte delivery or result readback.
// Define JTAG_DR_SCAN_CTRL_STATS_EN to add the byte_count / scan_count statistics outputs.
module jtag_dr_scan_ctrl #(
  parameter int BYTE_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                 tck,
  input  logic                 rst_n,
  jtag_dr_scan_ctrl_if.slave   bus
`ifdef JTAG_DR_SCAN_CTRL_STATS_EN
  ,
  output logic [31:0]          byte_count,
  output logic [15:0]          scan_count
`endif
);

  localparam int CNT_W = $clog2(RESULT_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(RESULT_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(BYTE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_RES  = CNT_W'(RESULT_WIDTH);

  typedef enum logic [1:0] {IDLE, CAPTURED, SHIFTING, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [RESULT_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]        bit_cnt;
  logic [BYTE_WIDTH-1:0]   byte_data_q;
  logic                    byte_valid_q;
  logic                    overflow_q;
  logic                    len_error_q;

  logic in_scan;
  logic do_load;
  logic do_shift;
  logic do_update;
  logic byte_hit;
  logic byte_accept;
  logic len_bad;

  assign bus.tdo        = shreg[0];
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.len_error  = len_error_q;

  // A capture always wins so a capture mid-scan restarts cleanly; update beats shift.
  always_comb begin
    in_scan     = (state == CAPTURED) || (state == SHIFTING);
    do_load     = bus.ir_is_user && bus.capture_dr;
    do_update   = bus.ir_is_user && !bus.capture_dr && bus.update_dr && in_scan;
    do_shift    = bus.ir_is_user && !bus.capture_dr && !bus.update_dr && bus.shift_dr && in_scan;
    byte_hit    = do_update && (bit_cnt == CNT_BYTE);
    byte_accept = byte_hit && (!byte_valid_q || bus.byte_ready);
    len_bad     = do_update && (bit_cnt != '0) && (bit_cnt != CNT_BYTE) && (bit_cnt != CNT_RES);

    state_nxt = state;
    if (!bus.ir_is_user)   state_nxt = IDLE;
    else if (do_load)      state_nxt = CAPTURED;
    else if (do_update)    state_nxt = DONE;
    else if (do_shift)     state_nxt = SHIFTING;
    else if (state == DONE) state_nxt = IDLE;
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (do_load) begin
      shreg   <= bus.result_valid ? bus.result : '0;
      bit_cnt <= '0;
    end else if (do_shift) begin
      shreg   <= {bus.tdi, shreg[RESULT_WIDTH-1:1]};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // The first bit shifted ends up lowest in the top BYTE_WIDTH bits, i.e. LSB-first.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      len_error_q  <= 1'b0;
    end else begin
      if (byte_accept) begin
        byte_data_q  <= shreg[RESULT_WIDTH-1 -: BYTE_WIDTH];
        byte_valid_q <= 1'b1;
      end else if (byte_valid_q && bus.byte_ready) begin
        byte_valid_q <= 1'b0;
      end
      if (byte_hit && !byte_accept) overflow_q  <= 1'b1;
      if (len_bad)                  len_error_q <= 1'b1;
    end
  end

`ifdef JTAG_DR_SCAN_CTRL_STATS_EN
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      byte_count <= '0;
      scan_count <= '0;
    end else begin
      if (byte_accept) byte_count <= byte_count + 32'd1;
      if (do_update)   scan_count <= scan_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtag_dr_scan_ctrl.sv
// Self-checking bench for jtag_dr_scan_ctrl: table of DR scans plus hand-written corner sequences,
// delivered bytes checked against a scoreboard queue.
module tb_jtag_dr_scan_ctrl;

  localparam int BW = 8;
  localparam int RW = 32;

  logic tck;
  logic rst_n;
`ifdef JTAG_DR_SCAN_CTRL_STATS_EN
  logic [31:0] byte_count;
  logic [15:0] scan_count;
`endif

  jtag_dr_scan_ctrl_if #(.BYTE_WIDTH(BW), .RESULT_WIDTH(RW)) bus ();

  jtag_dr_scan_ctrl #(.BYTE_WIDTH(BW), .RESULT_WIDTH(RW)) dut (
    .tck   (tck),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef JTAG_DR_SCAN_CTRL_STATS_EN
    ,
    .byte_count (byte_count),
    .scan_count (scan_count)
`endif
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] exp_b;

  typedef struct {
    string       name;
    int          len;
    logic [63:0] data;
    logic        rv;
    logic [31:0] res;
    logic        push;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_len_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  // Full DR scan; tdo is sampled on the falling edge ahead of each shift edge.
  task automatic scan(input int len, input logic [63:0] bits, input logic user, output logic [63:0] rd);
    rd = '0;
    bus.ir_is_user = user;
    bus.capture_dr = 1'b1;
    step();
    bus.capture_dr = 1'b0;
    bus.shift_dr   = 1'b1;
    for (int i = 0; i < len; i++) begin
      bus.tdi = bits[i];
      @(negedge tck);
      rd[i] = bus.tdo;
      step();
    end
    bus.shift_dr  = 1'b0;
    bus.tdi       = 1'b0;
    step();
    bus.update_dr = 1'b1;
    step();
    bus.update_dr = 1'b0;
  endtask

  always @(negedge tck) begin
    if (rst_n && bus.byte_valid && bus.byte_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.byte_data);
      end else begin
        exp_b = exp_q.pop_front();
        chk("byte_out", {56'd0, bus.byte_data}, {56'd0, exp_b});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;

    vecs[0] = '{name:"byte41", len:8,  data:64'h41,         rv:1'b0, res:32'h0,        push:1'b1, chk_rd:1'b0, exp_rd:32'h0,        exp_len_err:1'b0};
    vecs[1] = '{name:"rb_vld", len:32, data:64'h0,          rv:1'b1, res:32'hDEADBEEF, push:1'b0, chk_rd:1'b1, exp_rd:32'hDEADBEEF, exp_len_err:1'b0};
    vecs[2] = '{name:"rb_nv",  len:32, data:64'h0,          rv:1'b0, res:32'hDEADBEEF, push:1'b0, chk_rd:1'b1, exp_rd:32'h0,        exp_len_err:1'b0};
    vecs[3] = '{name:"byteC3", len:8,  data:64'hC3,         rv:1'b0, res:32'h0,        push:1'b1, chk_rd:1'b0, exp_rd:32'h0,        exp_len_err:1'b0};
    vecs[4] = '{name:"len5",   len:5,  data:64'h15,         rv:1'b0, res:32'h0,        push:1'b0, chk_rd:1'b0, exp_rd:32'h0,        exp_len_err:1'b1};
    vecs[5] = '{name:"len40",  len:40, data:64'hFFFFFFFFFF, rv:1'b0, res:32'h0,        push:1'b0, chk_rd:1'b0, exp_rd:32'h0,        exp_len_err:1'b1};
    vecs[6] = '{name:"byte0A", len:8,  data:64'h0A,         rv:1'b0, res:32'h0,        push:1'b1, chk_rd:1'b0, exp_rd:32'h0,        exp_len_err:1'b1};

    rst_n = 1'b0;
    bus.tdi = 1'b0;  bus.ir_is_user = 1'b1;
    bus.capture_dr = 1'b0;  bus.shift_dr = 1'b0;  bus.update_dr = 1'b0;
    bus.byte_ready = 1'b1;  bus.result = '0;  bus.result_valid = 1'b0;
    step(); step();
    @(negedge tck);
    chk("rst_tdo",   {63'd0, bus.tdo},        64'd0);
    chk("rst_data",  {56'd0, bus.byte_data},  64'd0);
    chk("rst_valid", {63'd0, bus.byte_valid}, 64'd0);
    chk("rst_ovf",   {63'd0, bus.overflow},   64'd0);
    chk("rst_lerr",  {63'd0, bus.len_error},  64'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      bus.result       = vecs[i].res;
      bus.result_valid = vecs[i].rv;
      bus.byte_ready   = 1'b1;
      if (vecs[i].push) exp_q.push_back(vecs[i].data[BW-1:0]);
      scan(vecs[i].len, vecs[i].data, 1'b1, rd);
      @(negedge tck);
      chk({vecs[i].name, "_valid"}, {63'd0, bus.byte_valid}, {63'd0, vecs[i].push});
      if (vecs[i].push) chk({vecs[i].name, "_data"}, {56'd0, bus.byte_data}, vecs[i].data & 64'hFF);
      chk({vecs[i].name, "_lerr"}, {63'd0, bus.len_error}, {63'd0, vecs[i].exp_len_err});
      chk({vecs[i].name, "_ovf"},  {63'd0, bus.overflow},  64'd0);
      step();
      @(negedge tck);
      chk({vecs[i].name, "_valid_drop"}, {63'd0, bus.byte_valid}, 64'd0);
      if (vecs[i].chk_rd) chk({vecs[i].name, "_rd"}, {32'd0, rd[31:0]}, {32'd0, vecs[i].exp_rd});
      step();
    end

    // Back-pressure: second byte overflows and is dropped, first byte held.
    bus.result_valid = 1'b0;
    bus.byte_ready   = 1'b0;
    exp_q.push_back(8'h31);
    scan(8, 64'h31, 1'b1, rd);
    @(negedge tck);
    chk("bp_valid1", {63'd0, bus.byte_valid}, 64'd1);
    chk("bp_ovf0",   {63'd0, bus.overflow},   64'd0);
    step();
    scan(8, 64'h32, 1'b1, rd);
    @(negedge tck);
    chk("bp_ovf1",   {63'd0, bus.overflow},   64'd1);
    chk("bp_hold",   {56'd0, bus.byte_data},  64'h31);
    chk("bp_valid2", {63'd0, bus.byte_valid}, 64'd1);
    step();
    bus.byte_ready = 1'b1;
    step();
    @(negedge tck);
    chk("bp_drain", {63'd0, bus.byte_valid}, 64'd0);
    chk("bp_ovf_sticky", {63'd0, bus.overflow}, 64'd1);
    step();

    // Pending byte, then reset asserted partway through the next scan.
    bus.byte_ready = 1'b0;
    scan(8, 64'h55, 1'b1, rd);
    @(negedge tck);
    chk("pend_valid", {63'd0, bus.byte_valid}, 64'd1);
    step();
    bus.capture_dr = 1'b1;
    step();
    bus.capture_dr = 1'b0;
    bus.shift_dr   = 1'b1;
    bus.tdi        = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    bus.shift_dr = 1'b0;
    bus.tdi      = 1'b0;
    #2;
    chk("mid_rst_tdo",   {63'd0, bus.tdo},        64'd0);
    chk("mid_rst_valid", {63'd0, bus.byte_valid}, 64'd0);
    chk("mid_rst_data",  {56'd0, bus.byte_data},  64'd0);
    chk("mid_rst_ovf",   {63'd0, bus.overflow},   64'd0);
    chk("mid_rst_lerr",  {63'd0, bus.len_error},  64'd0);
    step();
    rst_n = 1'b1;
    bus.byte_ready = 1'b1;
    step();

    // Strobes with USER not selected are ignored.
    scan(8, 64'h5A, 1'b0, rd);
    chk("nouser_tdo", {56'd0, rd[7:0]}, 64'd0);
    @(negedge tck);
    chk("nouser_valid", {63'd0, bus.byte_valid}, 64'd0);
    step();
    step();

    exp_q.push_back(8'h7A);
    scan(8, 64'h7A, 1'b1, rd);
    @(negedge tck);
    chk("post_rst_valid", {63'd0, bus.byte_valid}, 64'd1);
    chk("post_rst_data",  {56'd0, bus.byte_data},  64'h7A);
    step();
    step();

`ifdef JTAG_DR_SCAN_CTRL_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      logic [BW-1:0] b;
      b = BW'($urandom_range(0, 255));
      exp_q.push_back(b);
      scan(8, {56'd0, b}, 1'b1, rd);
    end
    bus.result       = 32'h12345678;
    bus.result_valid = 1'b1;
    scan(32, 64'h0, 1'b1, rd);
    chk("stats_rd", {32'd0, rd[31:0]}, 64'h12345678);
    @(negedge tck);
    chk("byte_count", {32'd0, byte_count}, 64'd100);
    chk("scan_count", {48'd0, scan_count}, 64'd101);
    step();
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
